// File: rtl/sra_shift_controller_pkg.sv
// Shared definitions for the multi-cycle arithmetic right shifter.
//   STATE_W    : width of the controller state register
//   DATA_W_DEF : default operand/result width
//   S_IDLE..S_DONE : state encodings, also visible on the debug state port
package sra_shift_controller_pkg;

  localparam int STATE_W    = 2;
  localparam int DATA_W_DEF = 8;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_LOAD  = 2'd1;
  localparam logic [STATE_W-1:0] S_SHIFT = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/sra_shift_controller_datapath.sv
// Datapath of the shifter: working shift register, remaining-shift counter,
// latched shift amount and the registered result.
//   clk, rst_n    : clock / async active-low reset
//   load          : capture din into sr, shamt into cnt and shamt_q
//   shift         : one-bit arithmetic right shift of sr, decrement cnt
//   reload        : restart cnt from shamt_q (repeat mode, sr keeps its value)
//   capture       : dout <= value sr takes at this edge
//   din, shamt    : operand and shift amount
//   cnt_is_one    : last shift step is happening this cycle
//   shamt_is_zero : latched shift amount is zero
//   dout          : last completed result
module sra_datapath
  import sra_shift_controller_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              reload,
  input  logic              capture,
  input  logic [DATA_W-1:0] din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic              cnt_is_one,
  output logic              shamt_is_zero,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0]  sr, sr_nxt;
  logic [SHAMT_W-1:0] cnt, shamt_q;

  // Value sr takes this edge; capture picks it up so dout sees the fresh result
  // both for a zero-length load and for the final shift step.
  always_comb begin
    sr_nxt = sr;
    if (load)       sr_nxt = din;
    else if (shift) sr_nxt = {sr[DATA_W-1], sr[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      shamt_q <= '0;
      dout    <= '0;
    end else begin
      sr <= sr_nxt;
      if (load) begin
        cnt     <= shamt;
        shamt_q <= shamt;
      end else if (shift) begin
        cnt <= cnt - 1'b1;
      end else if (reload) begin
        cnt <= shamt_q;
      end
      if (capture) dout <= sr_nxt;
    end
  end

  assign cnt_is_one    = (cnt == SHAMT_W'(1));
  assign shamt_is_zero = (shamt_q == '0);

endmodule

// File: rtl/sra_shift_controller.sv
// Multi-cycle signed arithmetic right shifter with controller FSM.
// Shifts one bit per cycle; reports via a one-cycle done pulse; optional
// repeat mode keeps re-shifting the running result by the latched amount.
//   clk, rst_n : clock / async active-low reset
//   start      : request, honoured only in IDLE (abort has priority)
//   din, shamt : operand and unsigned shift amount, captured in LOAD
//   repeat_en  : sampled in DONE, re-shift by latched amount
//   abort      : return to IDLE from any active state, dout held
//   busy       : state != IDLE
//   done       : high exactly while in DONE
//   dout       : last completed result
//   state      : debug view of the state register
module sra_shift_controller
  import sra_shift_controller_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               repeat_en,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  dout,
  output logic [STATE_W-1:0] state
);

  state_e st;
  logic   cnt_is_one, shamt_is_zero, shamt_in_zero;
  logic   load, shift, reload, capture;

  assign shamt_in_zero = (shamt == '0);

  // Strobes are all gated by abort so an aborted operation never disturbs dout.
  assign load    = (st == ST_LOAD)  && !abort;
  assign shift   = (st == ST_SHIFT) && !abort;
  assign reload  = (st == ST_DONE)  && !abort && repeat_en && !shamt_is_zero;
  assign capture = (load && shamt_in_zero) || (shift && cnt_is_one);

  sra_datapath #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .shift         (shift),
    .reload        (reload),
    .capture       (capture),
    .din           (din),
    .shamt         (shamt),
    .cnt_is_one    (cnt_is_one),
    .shamt_is_zero (shamt_is_zero),
    .dout          (dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:  if (start && !abort) st <= ST_LOAD;
        ST_LOAD:  if (abort)              st <= ST_IDLE;
                  else if (shamt_in_zero) st <= ST_DONE;
                  else                    st <= ST_SHIFT;
        ST_SHIFT: if (abort)           st <= ST_IDLE;
                  else if (cnt_is_one) st <= ST_DONE;
        ST_DONE:  if (abort)          st <= ST_IDLE;
                  else if (!repeat_en) st <= ST_IDLE;
                  // zero-length repeat parks in DONE with done held high
                  else if (!shamt_is_zero) st <= ST_SHIFT;
        default:  st <= ST_IDLE;
      endcase
    end
  end

  // Pure decode of the state register, no input-to-output path.
  assign state = st;
  assign busy  = (st != ST_IDLE);
  assign done  = (st == ST_DONE);

endmodule

// File: tb/tb_sra_shift_controller.sv
module tb_sra_shift_controller;

  logic       clk = 1'b0;
  logic       rst_n, start, repeat_en, abort;
  logic [7:0] din;
  logic [3:0] shamt;
  logic       busy, done;
  logic [7:0] dout;
  logic [1:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sra_shift_controller #(.DATA_W(8), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .shamt(shamt),
    .repeat_en(repeat_en), .abort(abort), .busy(busy), .done(done),
    .dout(dout), .state(state)
  );

  // Drive start just after edge k; returns just after edge k+1 (IDLE has sampled it).
  task automatic launch(input logic [7:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    start = 1'b1; din = d; shamt = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges since edge k until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if ({state, busy, done, dout} !== 12'h000) begin n_fail++;
      $display("FAIL reset_outputs: state=%0d busy=%b done=%b dout=%h, want all 0", state, busy, done, dout); end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    launch(8'hB4, 4'd2);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", busy); end
    wait_done(n);
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL lat_b4: got %0d want 4", n); end
    n_chk++; if (dout !== 8'hED) begin n_fail++; $display("FAIL dout_b4: got %h want ed", dout); end
    @(posedge clk); #1;
    n_chk++; if ({state, busy, done} !== 4'b0000) begin n_fail++;
      $display("FAIL back_idle: state=%0d busy=%b done=%b want 0", state, busy, done); end
  endtask

  task automatic test_zero_and_large;
    int n;
    launch(8'h7F, 4'd0); wait_done(n);
    n_chk++; if (n !== 2) begin n_fail++; $display("FAIL lat_sh0: got %0d want 2", n); end
    n_chk++; if (dout !== 8'h7F) begin n_fail++; $display("FAIL dout_sh0: got %h want 7f", dout); end
    launch(8'h40, 4'd9); wait_done(n);
    n_chk++; if (dout !== 8'h00) begin n_fail++; $display("FAIL dout_40_9: got %h want 00", dout); end
    launch(8'h80, 4'd12); wait_done(n);
    n_chk++; if (n !== 14) begin n_fail++; $display("FAIL lat_sh12: got %0d want 14", n); end
    n_chk++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL dout_80_12: got %h want ff", dout); end
    launch(8'hFF, 4'd15); wait_done(n);
    n_chk++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL dout_ff_15: got %h want ff", dout); end
    @(posedge clk); #1;
  endtask

  task automatic test_repeat;
    int n;
    logic [7:0] exp_seq [3] = '{8'hE0, 8'hF0, 8'hF8};
    repeat_en = 1'b1;
    launch(8'h80, 4'd1); wait_done(n);
    n_chk++; if (dout !== 8'hC0) begin n_fail++; $display("FAIL rep0: got %h want c0", dout); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rep_gap%0d: done=%b want 0", i, done); end
      @(posedge clk); #1;
      n_chk++; if (done !== 1'b1 || dout !== exp_seq[i]) begin n_fail++;
        $display("FAIL rep%0d: done=%b dout=%h want 1/%h", i + 1, done, dout, exp_seq[i]); end
    end
    repeat_en = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({state, busy} !== 3'b000) begin n_fail++; $display("FAIL rep_stop: state=%0d busy=%b want 0", state, busy); end
    // zero-length repeat parks in DONE; abort beats repeat_en
    repeat_en = 1'b1;
    launch(8'h7F, 4'd0); wait_done(n);
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b1 || state !== 2'd3 || dout !== 8'h7F) begin n_fail++;
      $display("FAIL rep_zero: done=%b state=%0d dout=%h want 1/3/7f", done, state, dout); end
    abort = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL abort_wins: state=%0d want 0", state); end
    abort = 1'b0; repeat_en = 1'b0;
  endtask

  task automatic test_abort;
    int n;
    logic seen;
    launch(8'h55, 4'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL abort_pre: state=%0d want 2", state); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_chk++; if (state !== 2'd0 || dout !== 8'h7F) begin n_fail++;
      $display("FAIL abort_idle: state=%0d dout=%h want 0/7f", state, dout); end
    seen = done;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; seen |= done; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_nodone: done seen=%b want 0", seen); end
    // start pulsed mid-SHIFT must not alter timing or queue a new operation
    launch(8'h55, 4'd5);
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1; n++;
      start = (n == 3);
    end
    start = 1'b0;
    n_chk++; if (n !== 7 || dout !== 8'h02) begin n_fail++;
      $display("FAIL start_busy: lat=%0d dout=%h want 7/02", n, dout); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL no_queue: state=%0d want 0", state); end
    // abort has priority over start in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_abort: state=%0d want 0", state); end
  endtask

  task automatic test_midreset;
    int n;
    launch(8'h55, 4'd5);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({state, busy, done, dout} !== 12'h000) begin n_fail++;
      $display("FAIL async_rst: state=%0d busy=%b done=%b dout=%h want 0", state, busy, done, dout); end
    #1 rst_n = 1'b1;
    launch(8'hF0, 4'd3); wait_done(n);
    n_chk++; if (n !== 5 || dout !== 8'hFE) begin n_fail++;
      $display("FAIL post_rst: lat=%0d dout=%h want 5/fe", n, dout); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; repeat_en = 1'b0; abort = 1'b0;
    din = 8'h00; shamt = 4'd0;
    test_reset;
    test_basic;
    test_zero_and_large;
    test_repeat;
    test_abort;
    test_midreset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
